// File: rtl/ad_frame_acq.sv
// ad_frame_acq: LTC2387 write-side acquisition front end.
// Averages 2^AVG_N ADC words per sample clock and fills ping-pong cache banks.
module ad_frame_acq #(
    parameter  int DATA_W    = 18,
    parameter  int FRAME_LEN = 256,
    parameter  int AVG_N     = 2,
    localparam int IDX_W     = $clog2(FRAME_LEN),
    localparam int ADDR_W    = IDX_W + 1
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic              spclk,
    input  logic [DATA_W-1:0] ad_data,
    output logic              wr,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              bank,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic              overrun,
    output logic              short_frame
);

    localparam int ACC_W = DATA_W + AVG_N;
    localparam int CNT_W = AVG_N + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_N   = CNT_W'((1 << AVG_N) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SYNC,
        S_WAIT_SP,
        S_ACCUM,
        S_WRITE
    } state_t;

    state_t r_state;
    state_t w_state_n;

    logic r_sync_d;
    logic r_sp_d;
    logic r_en_d;
    logic w_sync_rise;
    logic w_sp_rise;
    logic w_en_rise;

    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_n;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_n;
    logic [CNT_W-1:0]        r_n;
    logic [CNT_W-1:0]        w_n_n;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic [DATA_W-1:0]       w_avg;
    logic                    w_last;

    logic              r_wr;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_bank;
    logic              r_fd;
    logic [15:0]       r_cnt;
    logic              r_ovr;
    logic              r_short;

    logic              w_wr_n;
    logic [ADDR_W-1:0] w_waddr_n;
    logic [DATA_W-1:0] w_wdata_n;
    logic              w_bank_n;
    logic              w_fd_n;
    logic [15:0]       w_cnt_n;
    logic              w_ovr_n;
    logic              w_short_n;

    assign w_sync_rise = sync & ~r_sync_d;
    assign w_sp_rise   = spclk & ~r_sp_d;
    assign w_en_rise   = en & ~r_en_d;

    assign w_ext  = ACC_W'(signed'(ad_data));
    assign w_sum  = r_acc + w_ext;
    // floor division by 2^AVG_N: arithmetic shift truncates toward -inf
    assign w_avg  = DATA_W'(w_sum >>> AVG_N);
    assign w_last = (r_idx == LAST_IDX);

    assign wr          = r_wr;
    assign waddr       = r_waddr;
    assign wdata       = r_wdata;
    assign bank        = r_bank;
    assign frame_done  = r_fd;
    assign frame_cnt   = r_cnt;
    assign overrun     = r_ovr;
    assign short_frame = r_short;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_acc_n   = r_acc;
        w_n_n     = r_n;
        w_wr_n    = 1'b0;
        w_waddr_n = r_waddr;
        w_wdata_n = r_wdata;
        w_fd_n    = 1'b0;
        w_bank_n  = r_bank;
        w_cnt_n   = r_cnt;
        w_ovr_n   = r_ovr;
        w_short_n = r_short;

        // frame completion is committed once frame_done has been shown
        if (r_state == S_WRITE && w_last) begin
            w_bank_n = ~r_bank;
            w_cnt_n  = r_cnt + 16'd1;
        end

        if (w_en_rise) begin
            w_ovr_n   = 1'b0;
            w_short_n = 1'b0;
        end

        if (!en) begin
            w_state_n = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_n = S_WAIT_SYNC;
                end
                S_WAIT_SYNC: begin
                    if (w_sync_rise) begin
                        w_idx_n   = '0;
                        w_state_n = S_WAIT_SP;
                    end
                end
                S_WAIT_SP: begin
                    if (w_sync_rise) begin
                        w_short_n = 1'b1;
                        w_idx_n   = '0;
                    end else if (w_sp_rise) begin
                        w_acc_n = w_ext;
                        w_n_n   = CNT_W'(1);
                        if (AVG_N == 0) begin
                            w_wr_n    = 1'b1;
                            w_waddr_n = {r_bank, r_idx};
                            w_wdata_n = ad_data;
                            w_fd_n    = w_last;
                            w_state_n = S_WRITE;
                        end else begin
                            w_state_n = S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_sync_rise) begin
                        w_short_n = 1'b1;
                        w_idx_n   = '0;
                        w_state_n = S_WAIT_SP;
                    end else begin
                        if (w_sp_rise) begin
                            w_ovr_n = 1'b1;
                        end
                        w_acc_n = w_sum;
                        w_n_n   = r_n + CNT_W'(1);
                        if (r_n == LAST_N) begin
                            w_wr_n    = 1'b1;
                            w_waddr_n = {r_bank, r_idx};
                            w_wdata_n = w_avg;
                            w_fd_n    = w_last;
                            w_state_n = S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_sp_rise && !w_sync_rise) begin
                        w_ovr_n = 1'b1;
                    end
                    if (w_last) begin
                        // a sync on the closing cycle starts the next frame
                        w_idx_n   = '0;
                        w_state_n = w_sync_rise ? S_WAIT_SP : S_WAIT_SYNC;
                    end else if (w_sync_rise) begin
                        w_short_n = 1'b1;
                        w_idx_n   = '0;
                        w_state_n = S_WAIT_SP;
                    end else begin
                        w_idx_n   = r_idx + IDX_W'(1);
                        w_state_n = S_WAIT_SP;
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_sync_d <= 1'b0;
            r_sp_d   <= 1'b0;
            r_en_d   <= 1'b0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_n      <= '0;
            r_wr     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_bank   <= 1'b0;
            r_fd     <= 1'b0;
            r_cnt    <= '0;
            r_ovr    <= 1'b0;
            r_short  <= 1'b0;
        end else begin
            r_sync_d <= sync;
            r_sp_d   <= spclk;
            r_en_d   <= en;
            r_idx    <= w_idx_n;
            r_acc    <= w_acc_n;
            r_n      <= w_n_n;
            r_wr     <= w_wr_n;
            r_waddr  <= w_waddr_n;
            r_wdata  <= w_wdata_n;
            r_bank   <= w_bank_n;
            r_fd     <= w_fd_n;
            r_cnt    <= w_cnt_n;
            r_ovr    <= w_ovr_n;
            r_short  <= w_short_n;
        end
    end

endmodule

// File: doc/ad_frame_acq.md
# ad_frame_acq

Write-side acquisition front end for the LTC2387 path, in the ADC data clock domain, directly upstream of the ad_cache ping-pong buffer. Takes the free-running ADC word stream plus the already double-synchronised frame sync and sample clock. On each sample-clock rising edge it averages 2^AVG_N consecutive ADC words. It writes FRAME_LEN averaged samples per frame into the cache bank selected by `bank`, then flips banks so the USB side (cmd_decode) reads a complete frame.

## Interface
Parameters:
- DATA_W, 18: ADC word width (two's complement).
- FRAME_LEN, 256: samples per frame; power of two, ≥ 2.
- AVG_N, 2: log2 of conversions averaged per sample; 0..4.

Ports (ADDR_W = log2(FRAME_LEN)+1):
- mclk  in  1  ADC data clock (IN_AD_CLK); all logic on rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- en  in  1  acquisition enable, level.
- sync  in  1  frame sync, synchronised level.
- spclk  in  1  sample clock, synchronised level.
- ad_data  in  DATA_W  ADC word, valid every cycle.
- wr  out  1  cache write strobe, one cycle per sample.
- waddr  out  ADDR_W  {bank, sample index}.
- wdata  out  DATA_W  averaged sample.
- bank  out  1  bank currently being filled.
- frame_done  out  1  one-cycle pulse on the last write of a frame.
- frame_cnt  out  16  completed frames, wraps at 65535→0.
- overrun  out  1  sticky: spclk edge arrived while a sample was still averaging.
- short_frame  out  1  sticky: sync edge arrived before FRAME_LEN samples were written.

## Operation
- Edge detect: `sync_r` and `sp_r` hold the previous cycle's `sync` and `spclk`. A rise is `x & ~x_r`.
- States and transitions:
  - IDLE: when `en`=1, go to WAIT_SYNC.
  - WAIT_SYNC: on sync rise, set idx=0 and go to WAIT_SP.
  - WAIT_SP: on sp rise, set acc = sign-extended ad_data and n=1. Go to ACCUM, or to WRITE if AVG_N=0.
  - ACCUM: add sign-extended ad_data to acc each cycle and increment n. When n reaches 2^AVG_N-1 on this add, go to WRITE next cycle.
  - WRITE: see the write rules below. Afterwards go to WAIT_SP, or to WAIT_SYNC after the last sample.
- acc is DATA_W+AVG_N bits, signed. wdata = acc >>> AVG_N (arithmetic shift, truncation toward −∞). No overflow is possible.
- In WRITE, for one cycle:
  - wr=1, waddr={bank, idx}, wdata as above.
  - If idx=FRAME_LEN-1: frame_done=1 the same cycle; bank toggles and frame_cnt increments on the following edge; next state WAIT_SYNC.
  - Otherwise idx increments.
- Boundary conditions:
  - sync rise in WAIT_SP, ACCUM or WRITE before the last write: set short_frame, discard any in-progress average, suppress any write that cycle, idx=0, next state WAIT_SP. bank is not toggled, so the partial bank is overwritten.
  - sp rise while in ACCUM or WRITE: set overrun; the edge is ignored.
  - sync rise and sp rise in the same cycle: the sync rise wins (restart) and that sp edge is ignored, with no overrun.
  - en=0 in any state: next state IDLE; partial frame discarded. bank, frame_cnt and the flags are held.
  - Clearing flags: overrun and short_frame clear only on rst, or on a 0→1 transition of en.

## Timing
- Reset values: state=IDLE, wr=0, waddr=0, wdata=0, bank=0, frame_done=0, frame_cnt=0, overrun=0, short_frame=0. Edge registers reset to 0.
- Output registering: all outputs are registered. wr/waddr/wdata/frame_done are asserted in the cycle the FSM is in WRITE.
- Latency: sp rise sampled at edge t (ad_data at t is the first word); words t..t+2^AVG_N-1 are averaged; wr is high in cycle t+2^AVG_N.
- Throughput: minimum spclk period without overrun is 2^AVG_N+1 cycles.
- Bank and count update: bank flips and frame_cnt increments exactly one cycle after frame_done. The reader may treat the bank-toggle edge as the switch event.

## Test plan
- Nominal frame (AVG_N=2, FRAME_LEN=256): sync pulse, then 256 spclk rises every 20 cycles with ad_data ramping +1 per cycle from k. Required: wdata[i] = k+20i+1 (floor of mean of 4 words); addresses 0..255; frame_done on the 256th write; bank 0→1; frame_cnt=1.
- Negative averaging: ad_data words −3, −2, −2, −2. Required: wdata = −3 (floor of −9/4).
- Short frame: sync rise after 100 writes. Required: short_frame=1; next write at waddr={0, 0}; bank stays 0.
- Overrun: spclk period of 3 cycles with AVG_N=2. Required: overrun=1; one write per accepted edge; no write for the ignored edges.
- Enable drop mid-frame at sample 50, then re-enable. Required: no writes while en=0; overrun and short_frame cleared on re-enable; capture waits for a fresh sync; bank is unchanged.
- Async reset asserted mid-ACCUM, between clock edges. Required: all outputs go to their reset values immediately; wr=0 until a new sync and spclk sequence.
